// File: rtl/pio_ram_emu_link_if.sv
// Request/response bundle between the fetch client and the PIO RAM emulator link.
interface pio_ram_emu_link_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;
  logic                 rsp_timeout;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/pio_ram_emu_link.sv
// Link master for the external PIO RAM emulator: serialises requests as 2-bit
// symbol frames on tx_pins and deserialises read responses from rx_pins.
//
// state    | meaning
// IDLE     | ready for a request, tx line idle (00)
// TX_ADDR  | start symbol then address symbols on tx_pins
// TX_DATA  | write data symbols on tx_pins
// WAIT_RSP | read sent, waiting for 01 start symbol or timeout
// RX_DATA  | shifting in read data symbols
//
// The state always names what tx_pins is showing in the current cycle, so the
// symbol counter in TX_* holds the number of symbols already on the line.
module pio_ram_emu_link #(
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 16,
  parameter int TIMEOUT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  pio_ram_emu_link_if.slave   bus,
  output logic                busy,
  output logic [1:0]          tx_pins,
  input  logic [1:0]          rx_pins
);

  localparam int A     = ADDR_BITS / 2;
  localparam int D     = DATA_BITS / 2;
  localparam int SW    = ADDR_BITS + DATA_BITS;
  localparam int SYM_W = $clog2(A + D + 1);
  localparam int CW    = (SYM_W > TIMEOUT_BITS) ? SYM_W : TIMEOUT_BITS;

  localparam logic [CW-1:0] ADDR_END = CW'(A);
  localparam logic [CW-1:0] DATA_END = CW'(D);
  localparam logic [CW-1:0] RX_END   = CW'(D - 1);
  // Last wait cycle: the counter would reach 2**TIMEOUT_BITS-1 on this edge.
  localparam logic [CW-1:0] WAIT_END = CW'((1 << TIMEOUT_BITS) - 2);

  typedef enum logic [2:0] {
    IDLE,
    TX_ADDR,
    TX_DATA,
    WAIT_RSP,
    RX_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        sh_q, sh_d;
  logic                 wr_q, wr_d;
  logic [1:0]           tx_q, tx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_to_q, rsp_to_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

  assign bus.req_ready   = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign tx_pins         = tx_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.rsp_data    = rsp_data_q;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      wr_q        <= 1'b0;
      tx_q        <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      wr_q        <= wr_d;
      tx_q        <= tx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_to_q    <= rsp_to_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state, symbol shifting and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    wr_d        = wr_q;
    tx_d        = 2'b00;
    rsp_valid_d = 1'b0;
    rsp_to_d    = rsp_to_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = TX_ADDR;
          tx_d    = {bus.req_write, 1'b1};
          sh_d    = {bus.req_addr, bus.req_wdata};
          wr_d    = bus.req_write;
          cnt_d   = '0;
        end
      end
      TX_ADDR: begin
        if (cnt_q == ADDR_END) begin
          if (wr_q) begin
            state_d = TX_DATA;
            tx_d    = sh_q[SW-1 -: 2];
            sh_d    = {sh_q[SW-3:0], 2'b00};
            cnt_d   = CW'(1);
          end else begin
            state_d = WAIT_RSP;
            cnt_d   = '0;
          end
        end else begin
          tx_d  = sh_q[SW-1 -: 2];
          sh_d  = {sh_q[SW-3:0], 2'b00};
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == DATA_END) begin
          state_d = IDLE;
        end else begin
          tx_d  = sh_q[SW-1 -: 2];
          sh_d  = {sh_q[SW-3:0], 2'b00};
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_RSP: begin
        // A start symbol takes priority over an expiring wait counter.
        if (rx_pins == 2'b01) begin
          state_d = RX_DATA;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_END) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        sh_d = {sh_q[SW-3:0], rx_pins};
        if (cnt_q == RX_END) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b0;
          rsp_data_d  = sh_d[DATA_BITS-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pio_ram_emu_link.sv
// Directed bench for pio_ram_emu_link with tx-symbol and response scoreboards.
module tb_pio_ram_emu_link;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] tx_pins;
  logic [1:0] rx_pins;

  always #5 clk = ~clk;

  pio_ram_emu_link_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

  pio_ram_emu_link #(.ADDR_BITS(16), .DATA_BITS(16), .TIMEOUT_BITS(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .tx_pins (tx_pins),
    .rx_pins (rx_pins)
  );

  typedef struct {
    logic        to;
    logic [15:0] data;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  logic [1:0]  txq[$];
  rsp_t        rspq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input bit wr, input logic [15:0] a, input logic [15:0] d);
    txq.push_back({wr, 1'b1});
    for (int i = 7; i >= 0; i--) txq.push_back(a[2*i +: 2]);
    if (wr) for (int i = 7; i >= 0; i--) txq.push_back(d[2*i +: 2]);
    txq.push_back(2'b00);
  endtask

  task automatic push_rsp(input logic to, input logic [15:0] d);
    rsp_t r;
    r.to   = to;
    r.data = d;
    rspq.push_back(r);
  endtask

  // Waits for ready, offers one request, returns 2 time units after the accept edge.
  task automatic send_req(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    push_frame(wr, a, d);
    #2 bus.req_valid = 1'b0;
  endtask

  // Drives a response frame; optionally offers a write on the last symbol so it lands on the rsp_valid cycle.
  task automatic emu_reply(input logic [15:0] d, input bit with_start, input bit b2b);
    if (with_start) begin
      @(negedge clk);
      rx_pins = 2'b01;
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      rx_pins = d[2*i +: 2];
      check("rsp_early", {31'b0, bus.rsp_valid}, 32'd0);
      if (b2b && i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'hC3C3;
        bus.req_wdata = 16'h0FF0;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_lat", {31'b0, bus.rsp_valid}, 32'd1);
    if (b2b) begin
      check("b2b_ready", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clk);
      push_frame(1'b1, 16'hC3C3, 16'h0FF0);
      #2 bus.req_valid = 1'b0;
      check("b2b_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    rx_pins = 2'b00;
    @(posedge clk);
    #1;
    check("rsp_pulse", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  // Per-cycle tx symbol check; line must be idle whenever no frame is expected.
  always @(posedge clk) begin
    #1;
    if (txq.size() > 0) check("tx", {30'b0, tx_pins}, {30'b0, txq.pop_front()});
    else                check("tx_idle", {30'b0, tx_pins}, 32'd0);
  end

  // Response scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.rsp_valid) begin
      if (rspq.size() == 0) begin
        check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
      end else begin
        rsp_t e;
        e = rspq.pop_front();
        check("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, e.to});
        check("rsp_data", {16'b0, bus.rsp_data}, {16'b0, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rx_pins       = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {30'b0, tx_pins}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
    check("rst_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'd0);
    rst_n = 1'b1;

    // Read 0x1234, response 0xBEEF
    send_req(1'b0, 16'h1234, 16'hFFFF);
    push_rsp(1'b0, 16'hBEEF);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      check("t1_ready_low", {31'b0, bus.req_ready}, 32'd0);
      check("t1_busy", {31'b0, busy}, 32'd1);
    end
    emu_reply(16'hBEEF, 1'b1, 1'b0);

    // Start symbols while idle and during TX_ADDR are dropped
    @(negedge clk);
    rx_pins = 2'b01;
    @(negedge clk);
    rx_pins = 2'b00;
    send_req(1'b0, 16'h4321, 16'h0000);
    push_rsp(1'b0, 16'h5A3C);
    @(negedge clk);
    @(negedge clk);
    rx_pins = 2'b01;
    @(negedge clk);
    rx_pins = 2'b00;
    check("t5_busy", {31'b0, busy}, 32'd1);
    repeat (8) @(posedge clk);
    emu_reply(16'h5A3C, 1'b1, 1'b0);

    // Reset in the middle of TX_ADDR
    send_req(1'b0, 16'h9999, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_tx", {30'b0, tx_pins}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_ready", {31'b0, bus.req_ready}, 32'd1);
    txq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Write 0x0001 <- 0xA5A5; ready returns after the last data symbol
    send_req(1'b1, 16'h0001, 16'hA5A5);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      check("t3_ready", {31'b0, bus.req_ready}, (c == 18) ? 32'd1 : 32'd0);
    end

    // Read, then a write offered on the response cycle
    send_req(1'b0, 16'h2468, 16'h0000);
    push_rsp(1'b0, 16'h7777);
    repeat (10) @(posedge clk);
    emu_reply(16'h7777, 1'b1, 1'b1);

    // Read after the back-to-back write
    send_req(1'b0, 16'hFFFF, 16'h0000);
    push_rsp(1'b0, 16'h0001);
    repeat (9) @(posedge clk);
    emu_reply(16'h0001, 1'b1, 1'b0);

    // Timeout with 10/11 noise on rx
    send_req(1'b0, 16'h00F0, 16'h0000);
    push_rsp(1'b1, 16'h0000);
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 20) rx_pins = 2'b10;
      if (c == 25) rx_pins = 2'b11;
      if (c == 30) rx_pins = 2'b00;
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("timeout_latency", lat, 32'd73);

    // Start symbol on the last wait cycle wins over the timeout
    send_req(1'b0, 16'h1111, 16'h0000);
    push_rsp(1'b0, 16'h1357);
    repeat (71) @(posedge clk);
    @(negedge clk);
    rx_pins = 2'b01;
    emu_reply(16'h1357, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("rsp_missing", rspq.size(), 32'd0);
    check("tx_pending", txq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
